// File: rtl/ca_rule_stage.sv
// Row sequencer and elementary-CA rule evaluator wrapped around an external shift buffer.
// Streams one row in, evaluates each 22-bit window and streams the next generation out.
module ca_rule_stage #(
  parameter int unsigned WordsPerRow = 32
) (
  input  logic        clk_i,
  input  logic        clear_ni,
  input  logic        start_i,
  input  logic [7:0]  rule_i,
  input  logic [19:0] in_word_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        buf_clear_o,
  output logic        buf_shift_o,
  output logic [19:0] buf_din_o,
  input  logic [21:0] buf_window_i,
  output logic [19:0] out_word_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        row_done_o
);

  localparam int unsigned CntW = $clog2(WordsPerRow + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(WordsPerRow - 1);

  typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_e;

  state_e          state_q, state_d;
  logic [7:0]      rule_q, rule_d;
  logic [CntW-1:0] in_cnt_q, in_cnt_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic            pend_q, pend_d;
  logic            out_valid_q, out_valid_d;
  logic [19:0]     out_word_q, out_word_d;

  logic        load, shift_ok, feed_shift, flush_shift, out_hs, last_hs;
  logic [19:0] result;

  // State register
  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) begin
      state_q     <= StIdle;
      rule_q      <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      rule_q      <= rule_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  // Rule lookup: each cell indexes the rule with its {left, centre, right} neighbourhood
  always_comb begin
    result = '0;
    for (int i = 0; i < 20; i++) begin
      result[i] = rule_q[buf_window_i[i+2 -: 3]];
    end
  end

  // Handshake and shift qualification
  always_comb begin
    load        = pend_q && (!out_valid_q || out_ready_i);
    shift_ok    = !pend_q || load;
    feed_shift  = (state_q == StFeed) && shift_ok && in_valid_i;
    flush_shift = (state_q == StFlush) && shift_ok;
    out_hs      = out_valid_q && out_ready_i;
    last_hs     = (state_q == StDrain) && !pend_q && out_hs && (out_cnt_q == LastIdx);
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rule_d      = rule_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rule_d    = rule_i;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = StFeed;
        end
      end
      StFeed: begin
        if (feed_shift) begin
          in_cnt_d = in_cnt_q + CntW'(1);
          if (in_cnt_q == LastIdx) state_d = StFlush;
        end
      end
      StFlush: begin
        if (flush_shift) state_d = StDrain;
      end
      StDrain: begin
        if (last_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (out_hs) out_cnt_d = out_cnt_q + CntW'(1);

    if (load) begin
      out_word_d  = result;
      out_valid_d = 1'b1;
      pend_d      = 1'b0;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // The first shift of a row only primes the buffer; every later one completes a window
    if (flush_shift || (feed_shift && in_cnt_q != '0)) pend_d = 1'b1;
  end

  // Outputs
  always_comb begin
    in_ready_o  = (state_q == StFeed) && shift_ok;
    buf_clear_o = (state_q == StIdle);
    buf_shift_o = feed_shift || flush_shift;
    buf_din_o   = (state_q == StFeed) ? in_word_i : 20'h0;
    out_word_o  = out_word_q;
    out_valid_o = out_valid_q;
    busy_o      = (state_q != StIdle);
    row_done_o  = last_hs;
  end

endmodule

// File: tb/tb_ca_rule_stage.sv
// Bench for ca_rule_stage: three instances (1, 2 and 4 words per row), each with a
// behavioural shift buffer; expected words queue up at stimulus time and a monitor pops them.
module tb_ca_rule_stage;

  logic        clk;
  logic        clear_n;
  logic        start      [3];
  logic [7:0]  rule       [3];
  logic [19:0] in_word    [3];
  logic        in_valid   [3];
  logic        in_ready   [3];
  logic        buf_clear  [3];
  logic        buf_shift  [3];
  logic [19:0] buf_din    [3];
  logic [21:0] buf_window [3];
  logic [19:0] out_word   [3];
  logic        out_valid  [3];
  logic        out_ready  [3];
  logic        busy       [3];
  logic        row_done   [3];

  int n_pass = 0;
  int n_total = 0;
  int rd_cnt [3];
  int out_cnt [3];
  logic [19:0] q0[$];
  logic [19:0] q1[$];
  logic [19:0] q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned W = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [19:0] r0, r1, r2;

    ca_rule_stage #(.WordsPerRow(W)) u_dut (
      .clk_i       (clk),
      .clear_ni    (clear_n),
      .start_i     (start[g]),
      .rule_i      (rule[g]),
      .in_word_i   (in_word[g]),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .buf_clear_o (buf_clear[g]),
      .buf_shift_o (buf_shift[g]),
      .buf_din_o   (buf_din[g]),
      .buf_window_i(buf_window[g]),
      .out_word_o  (out_word[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .busy_o      (busy[g]),
      .row_done_o  (row_done[g])
    );

    // Shift buffer model: r0 newest word, window = {r2[0], r1, r0[19]}
    always @(posedge clk) begin
      if (buf_clear[g]) begin
        r0 <= '0;
        r1 <= '0;
        r2 <= '0;
      end else if (buf_shift[g]) begin
        r2 <= r1;
        r1 <= r0;
        r0 <= buf_din[g];
      end
    end
    assign buf_window[g] = {r2[0], r1, r0[19]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input int g, input logic [19:0] w);
    case (g)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic pop(input int g, output bit ok, output logic [19:0] w);
    ok = 1'b0;
    w  = '0;
    case (g)
      0: if (q0.size() > 0) begin ok = 1'b1; w = q0.pop_front(); end
      1: if (q1.size() > 0) begin ok = 1'b1; w = q1.pop_front(); end
      default: if (q2.size() > 0) begin ok = 1'b1; w = q2.pop_front(); end
    endcase
  endtask

  function automatic int qsize(input int g);
    case (g)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Monitor: a handshake seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (row_done[g]) rd_cnt[g]++;
      if (clear_n && out_valid[g] && out_ready[g]) begin
        bit ok;
        logic [19:0] e;
        pop(g, ok, e);
        out_cnt[g]++;
        if (!ok) chk($sformatf("unexpected_out[%0d]", g), {12'h0, out_word[g]}, 32'hFFFF_FFFF);
        else chk($sformatf("out_word[%0d]", g), {12'h0, out_word[g]}, {12'h0, e});
      end
    end
  end

  task automatic start_row(input int g, input logic [7:0] r);
    @(posedge clk); #1;
    start[g] = 1'b1;
    rule[g]  = r;
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic feed(input int g, input logic [19:0] w);
    int n = 0;
    in_valid[g] = 1'b1;
    in_word[g]  = w;
    @(negedge clk);
    while (!in_ready[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("feed_timeout[%0d]", g), n >= 100, 0);
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int rd_before);
    int n = 0;
    @(negedge clk);
    while (busy[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_timeout[%0d]", g), n >= 200, 0);
    chk($sformatf("queue_drained[%0d]", g), qsize(g), 0);
    chk($sformatf("row_done_count[%0d]", g), rd_cnt[g] - rd_before, 1);
  endtask

  initial begin
    int rd;
    int n;
    clear_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0; rule[g] = '0; in_word[g] = '0; in_valid[g] = 1'b0;
      out_ready[g] = 1'b1; rd_cnt[g] = 0; out_cnt[g] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid[2], 0);
    chk("rst_out_word", out_word[2], 0);
    chk("rst_busy", busy[2], 0);
    chk("rst_in_ready", in_ready[2], 0);
    chk("rst_row_done", row_done[2], 0);
    chk("rst_buf_clear", buf_clear[2], 1);
    chk("rst_buf_shift", buf_shift[2], 0);
    @(posedge clk); #1;
    clear_n = 1'b1;

    // 1: rule 90, two words
    rd = rd_cnt[1];
    push(1, 20'h00002); push(1, 20'h80000);
    start_row(1, 8'd90);
    feed(1, 20'h00001);
    feed(1, 20'h00000);
    wait_idle(1, rd);

    // 2: rule 8, boundary cells
    rd = rd_cnt[1];
    push(1, 20'h80000); push(1, 20'h00000);
    start_row(1, 8'd8);
    feed(1, 20'hFFFFF);
    feed(1, 20'hFFFFF);
    wait_idle(1, rd);

    // 3: rule 255 with a 10-cycle output stall
    rd = rd_cnt[2];
    for (int i = 0; i < 4; i++) push(2, 20'hFFFFF);
    out_ready[2] = 1'b0;
    start_row(2, 8'd255);
    fork
      begin
        for (int i = 0; i < 4; i++) feed(2, 20'h12345 + 20'(i));
      end
    join_none
    n = 0;
    @(negedge clk);
    while (!out_valid[2] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_timeout", n >= 100, 0);
    repeat (10) @(negedge clk);
    chk("stall_out_valid", out_valid[2], 1);
    chk("stall_out_word", out_word[2], 20'hFFFFF);
    chk("stall_in_ready", in_ready[2], 0);
    @(posedge clk); #1;
    out_ready[2] = 1'b1;
    wait fork;
    wait_idle(2, rd);

    // 4: single-word row, rule 1
    push(0, 20'hFFFFF);
    start_row(0, 8'd1);
    feed(0, 20'h00000);
    n = 0;
    @(negedge clk);
    while (!row_done[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w1_done_timeout", n >= 100, 0);
    chk("w1_busy_at_done", busy[0], 1);
    @(negedge clk);
    chk("w1_busy_after_done", busy[0], 0);
    chk("w1_row_done_count", rd_cnt[0], 1);
    chk("w1_queue_drained", qsize(0), 0);

    // 5: reset mid-row after two outputs, then a clean row
    push(2, 20'h80000); push(2, 20'h00000); push(2, 20'h00000); push(2, 20'h00001);
    out_cnt[2] = 0;
    start_row(2, 8'd90);
    for (int i = 0; i < 4; i++) feed(2, 20'hFFFFF);
    n = 0;
    while (out_cnt[2] < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("mid_reset_timeout", n >= 100, 0);
    #1;
    clear_n = 1'b0;
    q2.delete();
    #1;
    chk("mid_rst_out_valid", out_valid[2], 0);
    chk("mid_rst_busy", busy[2], 0);
    chk("mid_rst_in_ready", in_ready[2], 0);
    repeat (2) @(posedge clk);
    #1;
    clear_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_out_valid", out_valid[2], 0);
    chk("post_rst_in_ready", in_ready[2], 0);
    rd = rd_cnt[2];
    push(2, 20'h40000); push(2, 20'h00000); push(2, 20'h00000); push(2, 20'h00002);
    start_row(2, 8'd90);
    feed(2, 20'h80000);
    feed(2, 20'h00000);
    feed(2, 20'h00000);
    feed(2, 20'h00001);
    wait_idle(2, rd);

    // 6: start with rule 0 during FEED is ignored
    rd = rd_cnt[1];
    push(1, 20'h00002); push(1, 20'h80000);
    start_row(1, 8'd90);
    feed(1, 20'h00001);
    start[1] = 1'b1;
    rule[1]  = 8'd0;
    @(posedge clk); #1;
    start[1] = 1'b0;
    chk("restart_busy", busy[1], 1);
    feed(1, 20'h00000);
    wait_idle(1, rd);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
